riscv_data_mem_responder: RTL and testbench
===========================================

Name: riscv_data_mem_responder

Overview:
- Responder end of the multicycle core's data-memory interface: accepts MemRead/MemWrite requests on dAddress/dWriteData and returns dReadData.
- Holds a word-organised data RAM covering a fixed address window.
- Supports RISC-V byte, half and word loads and stores, with a configurable number of wait states.
- Signals completion with a one-cycle ack so the core's MEM state can stall until the data is ready.

Parameters:
- DEPTH, 1024: number of 32-bit words in the array; power of two, at least 4.
- BASE_ADDR, 32'h0000_2000: byte address of word 0; must be 4-byte aligned.
- WAIT_STATES, 1: extra cycles between request acceptance and ack; range 0..15.

Ports:
- clk  input  1  global clock; everything is on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- MemRead  input  1  read request from the core.
- MemWrite  input  1  write request from the core.
- dAddress  input  32  byte address of the request.
- dWriteData  input  32  store data; the low byte or half is used for SB/SH.
- funct3  input  3  RISC-V size/sign field of the load or store.
- dReadData  output  32  load result, aligned and extended.
- dAck  output  1  one-cycle completion pulse.
- dErr  output  1  valid with dAck; 1 means the access faulted.
- busy  output  1  high while a request is in flight.

Behaviour:
- Reset values: dReadData=0, dAck=0, dErr=0, busy=0, state=IDLE. The memory array is never cleared by reset.
- States:
  - IDLE: accept a request when MemRead|MemWrite is high. Latch address, write data, funct3 and op. Go to WAIT if WAIT_STATES>0, otherwise go to RESP. busy=1 from the cycle after acceptance.
  - WAIT: down-counter loaded with WAIT_STATES-1; go to RESP when it reaches 0.
  - RESP: for one cycle drive dAck=1, dErr and (for loads) dReadData. Commit the store to the array. Return to IDLE.
- Latency: dAck is high exactly WAIT_STATES+1 cycles after the accepting edge.
- Requests arriving while busy=1 or in RESP are ignored; the initiator holds requests until it sees dAck.
- dReadData:
  - Loads: holds its value after dAck until the next load completes.
  - Stores: left unchanged.
  - Faulting loads: returns 0.
- Range check: in range iff BASE_ADDR <= dAddress < BASE_ADDR + 4*DEPTH. Word index = (dAddress - BASE_ADDR) >> 2, truncated to $clog2(DEPTH) bits.
- Loads by funct3:
  - 000 LB: sign-extend byte lane dAddress[1:0].
  - 001 LH: sign-extend half lane dAddress[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte lane.
  - 101 LHU: zero-extend half lane.
  - Any other code: fault.
- Stores by funct3:
  - 000 SB: write one byte lane only.
  - 001 SH: write one half only.
  - 010 SW: write the full word.
  - Any other code: fault.
  - Lanes not written keep their contents.
- dErr=1 (no array write, dReadData=0 for loads) when any of these holds:
  - address out of range;
  - misaligned access (half with addr[0]=1, word with addr[1:0]!=0);
  - illegal funct3;
  - MemRead and MemWrite both high at acceptance.
- A read of the array returns the data as of the start of the request. There is no write-then-read hazard because only one request is in flight.
- Reset mid-operation: the FSM returns to IDLE immediately. An uncommitted store is discarded and no dAck is issued.

Optional Feature:
- Macro: RISCV_DMEM_STATS_EN.
- When defined:
  - Adds outputs rd_count[31:0], wr_count[31:0] and err_count[15:0].
  - Each counter increments on a dAck of the matching kind. Faulted accesses count only in err_count.
  - All counters reset to 0 and saturate at their maximum value.
- When undefined: the counters and their ports do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - the state enum {IDLE, WAIT, RESP};
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the default BASE_ADDR constant.
- One combinational sub-module, riscv_mem_align:
  - load path: lane select with sign/zero extension;
  - store path: byte-enable plus lane-shifted write data;
  - misalignment and illegal-funct3 fault flag.

Test Plan:
- SW 0xDEADBEEF to 0x2000, then LW 0x2000 (WAIT_STATES=1) -> each dAck arrives 2 cycles after acceptance; LW returns 0xDEADBEEF with dErr=0.
- After the first test, SB 0x55 to 0x2001, then LW 0x2000 -> 0xDEAD55EF. LB 0x2003 -> 0xFFFFFFDE; LBU 0x2003 -> 0x000000DE; LHU 0x2002 -> 0x0000DEAD.
- Faults:
  - LW at 0x2002 -> dErr=1, dReadData=0;
  - SW at 0x1FFC -> dErr=1 and the array is unchanged;
  - funct3=3'b011 -> dErr=1.
- MemRead and MemWrite both high at 0x2000 -> dErr=1 and no write. A second request issued while busy=1 -> ignored, with exactly one dAck.
- Assert rst low in the WAIT state of an SW to 0x2004 holding 0x12345678 -> no dAck, busy=0. A subsequent LW 0x2004 returns the old contents.
- With RISCV_DMEM_STATS_EN and WAIT_STATES=0: 3 good loads, 2 good stores, 1 fault -> dAck 1 cycle after each acceptance; rd_count=3, wr_count=2, err_count=1.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared FSM states, RISC-V load/store funct3 codes and default window base
package riscv_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_2000;
endpackage

// File: rtl/riscv_mem_align.sv
// riscv_mem_align: load lane select/extension, store byte enables and lane replication,
// plus misalignment/illegal-funct3 fault detection
module riscv_mem_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        is_store,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [3:0]  byte_en,
   output logic [31:0] store_data,
   output logic        fault
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        legal;
   logic        misaligned;
   always_comb begin
      lane_b     = rword[8*addr_lo +: 8];
      lane_h     = addr_lo[1] ? rword[31:16] : rword[15:0];
      load_data  = funct3 == F3_B  ? {{24{lane_b[7]}}, lane_b} :
                   funct3 == F3_H  ? {{16{lane_h[15]}}, lane_h} :
                   funct3 == F3_W  ? rword :
                   funct3 == F3_BU ? {24'b0, lane_b} :
                   funct3 == F3_HU ? {16'b0, lane_h} : 32'b0;
      byte_en    = funct3 == F3_B ? 4'b0001 << addr_lo :
                   funct3 == F3_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                   funct3 == F3_W ? 4'b1111 : 4'b0000;
      // replicate narrow data across lanes so byte_en alone picks the target lane
      store_data = funct3 == F3_B ? {4{wdata[7:0]}} :
                   funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
      legal      = is_store ? funct3 inside {F3_B, F3_H, F3_W}
                            : funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
      fault      = !legal || misaligned;
   end
endmodule

// File: rtl/riscv_data_mem_responder.sv
// riscv_data_mem_responder: multicycle data-memory responder with wait states and one-cycle ack.
// Define RISCV_DMEM_STATS_EN to add saturating read/write/error counters.
module riscv_data_mem_responder
   import riscv_mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] dAddress,
   input  logic [31:0] dWriteData,
   input  logic [2:0]  funct3,
   output logic [31:0] dReadData,
   output logic        dAck,
   output logic        dErr,
   output logic        busy
`ifdef RISCV_DMEM_STATS_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic [15:0] err_count
`endif
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [3:0] WS_M1 = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_q [DEPTH];

   logic [AW-1:0] idx;
   logic [31:0]   rword;
   logic [31:0]   ld_data;
   logic [31:0]   st_data;
   logic [3:0]    byte_en;
   logic          al_fault;
   logic          in_range;
   logic          err;
   logic          resp;
   logic          commit;

   // base is word aligned, so the word index is a difference of the index bits alone
   assign idx      = addr_q[AW+1:2] - BASE_ADDR[AW+1:2];
   assign rword    = mem_q[idx];
   assign in_range = addr_q >= BASE_ADDR && {1'b0, addr_q} < LIMIT;
   assign err      = !in_range || al_fault || (rd_q && wr_q);
   assign resp     = state_q == RESP;
   assign commit   = resp && wr_q && !err;

   riscv_mem_align u_align (
      .funct3    (f3_q),
      .addr_lo   (addr_q[1:0]),
      .is_store  (wr_q && !rd_q),
      .rword     (rword),
      .wdata     (wdata_q),
      .load_data (ld_data),
      .byte_en   (byte_en),
      .store_data(st_data),
      .fault     (al_fault)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      if (state_q == IDLE && (MemRead || MemWrite)) begin
         addr_d  = dAddress;
         wdata_d = dWriteData;
         f3_d    = funct3;
         rd_d    = MemRead;
         wr_d    = MemWrite;
         cnt_d   = WS_M1;
         state_d = WAIT_STATES > 0 ? WAIT : RESP;
      end
      if (state_q == WAIT) begin
         cnt_d   = cnt_q - 4'd1;
         state_d = cnt_q == 4'd0 ? RESP : WAIT;
      end
      if (resp) begin
         state_d = IDLE;
         rdata_d = rd_q ? (err ? 32'b0 : ld_data) : rdata_q;
      end
   end

   assign dReadData = rdata_d;
   assign dAck      = resp;
   assign dErr      = resp && err;
   assign busy      = state_q != IDLE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (commit)
         for (int b = 0; b < 4; b++)
            if (byte_en[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
   end

`ifdef RISCV_DMEM_STATS_EN
   logic [31:0] rd_count_q, rd_count_d;
   logic [31:0] wr_count_q, wr_count_d;
   logic [15:0] err_count_q, err_count_d;
   always_comb begin
      rd_count_d  = rd_count_q;
      wr_count_d  = wr_count_q;
      err_count_d = err_count_q;
      if (resp && !err && rd_q && rd_count_q != '1) rd_count_d = rd_count_q + 32'd1;
      if (resp && !err && wr_q && wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
      if (resp && err && err_count_q != '1) err_count_d = err_count_q + 16'd1;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_count_q  <= '0;
         wr_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         rd_count_q  <= rd_count_d;
         wr_count_q  <= wr_count_d;
         err_count_q <= err_count_d;
      end
   end
   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;
   assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// tb_riscv_data_mem_responder: randomized scoreboard bench against a byte-array reference model
module tb_riscv_data_mem_responder;
   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int unsigned WS    = 1;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] dAddress = '0;
   logic [31:0] dWriteData = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] dReadData;
   logic        dAck;
   logic        dErr;
   logic        busy;
`ifdef RISCV_DMEM_STATS_EN
   logic [31:0] rd_count;
   logic [31:0] wr_count;
   logic [15:0] err_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t exp_q[$];
   logic [7:0]  mb [4*DEPTH];
   logic [31:0] last_rd = '0;
   int n_rd = 0;
   int n_wr = 0;
   int n_err = 0;

   riscv_data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
      .clk       (clk),
      .rst       (rst_n),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .dAddress  (dAddress),
      .dWriteData(dWriteData),
      .funct3    (funct3),
      .dReadData (dReadData),
      .dAck      (dAck),
      .dErr      (dErr),
      .busy      (busy)
`ifdef RISCV_DMEM_STATS_EN
      ,
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // reference: memory as bytes, RISC-V rules applied directly
   task automatic model(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output exp_t e);
      int n;
      bit legal;
      bit bad;
      longint off;
      logic [31:0] v;
      n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      off = longint'(a) - longint'(BASE);
      bad = (rd && wr) || !legal || off < 0 || off >= 4 * DEPTH || (a % n) != 0;
      if (rd) begin
         v = '0;
         if (!bad) begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = mb[off + i];
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
         end
         last_rd = v;
      end else if (!bad) begin
         for (int i = 0; i < n; i++) mb[off + i] = wd[8*i +: 8];
      end
      if (bad) n_err++;
      else if (rd) n_rd++;
      else n_wr++;
      e.err  = bad;
      e.data = last_rd;
   endtask

   task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input bit glitch);
      exp_t e;
      int n;
      @(negedge clk);
      model(rd, wr, a, wd, f3, e);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      MemRead = rd;
      MemWrite = wr;
      dAddress = a;
      dWriteData = wd;
      funct3 = f3;
      if (glitch) begin
         @(negedge clk);
         MemRead = 1'b0;
         MemWrite = 1'b1;
         dWriteData = $urandom;
         funct3 = 3'b010;
      end
      n = 0;
      while (!dAck && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n == 40) check("ack_timeout", 32'd0, 32'd1);
      MemRead = 1'b0;
      MemWrite = 1'b0;
   endtask

   // the core captures dAck at edge cyc+1 of the negedge where it is seen
   always @(negedge clk) begin
      if (rst_n && dAck) begin
         if (exp_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dErr", 32'(dErr), 32'(e.err));
            check("dReadData", dReadData, e.data);
            check("latency", 32'(cyc + 1 - e.acc), 32'(WS + 1));
         end
      end
   end

   initial begin
      logic [2:0] ld_f3 [5];
      logic [2:0] st_f3 [3];
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      st_f3 = '{3'd0, 3'd1, 3'd2};
      #1;
      check("rst_dReadData", dReadData, 32'd0);
      check("rst_dAck", 32'(dAck), 32'd0);
      check("rst_dErr", 32'(dErr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int w = 0; w < DEPTH; w++) req(1'b0, 1'b1, BASE + 32'(4 * w), $urandom, 3'b010, 1'b0);
      req(1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'b010, 1'b0);
      req(1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 1'b0);
      req(1'b0, 1'b1, 32'h2001, 32'h55, 3'b000, 1'b0);
      req(1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 1'b0);
      req(1'b1, 1'b0, 32'h2003, 32'h0, 3'b000, 1'b0);
      req(1'b1, 1'b0, 32'h2003, 32'h0, 3'b100, 1'b0);
      req(1'b1, 1'b0, 32'h2002, 32'h0, 3'b101, 1'b0);
      req(1'b1, 1'b0, 32'h2002, 32'h0, 3'b010, 1'b0);
      req(1'b0, 1'b1, 32'h1FFC, 32'hCAFEF00D, 3'b010, 1'b0);
      req(1'b1, 1'b0, 32'h2000, 32'h0, 3'b011, 1'b0);
      req(1'b1, 1'b1, 32'h2000, 32'h11111111, 3'b010, 1'b0);
      req(1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 1'b0);
      req(1'b1, 1'b0, 32'h2008, 32'h0, 3'b010, 1'b1);
      req(1'b1, 1'b0, 32'h2008, 32'h0, 3'b010, 1'b0);
      // store interrupted by reset while waiting
      @(negedge clk);
      MemWrite = 1'b1;
      dAddress = 32'h2004;
      dWriteData = 32'h12345678;
      funct3 = 3'b010;
      @(negedge clk);
      rst_n = 1'b0;
      MemWrite = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("rst_mid_ack", 32'(dAck), 32'd0);
      end
      rst_n = 1'b1;
      last_rd = '0;
`ifdef RISCV_DMEM_STATS_EN
      n_rd = 0;
      n_wr = 0;
      n_err = 0;
`endif
      req(1'b1, 1'b0, 32'h2004, 32'h0, 3'b010, 1'b0);
      for (int k = 0; k < 200; k++) begin
         logic rd;
         logic wr;
         logic [2:0] f3;
         logic [31:0] a;
         int r;
         int sz;
         r = $urandom % 16;
         rd = r <= 7;
         wr = r == 0 || r >= 8;
         f3 = ($urandom % 8 == 0) ? 3'($urandom) : wr && !rd ? st_f3[$urandom % 3] : ld_f3[$urandom % 5];
         sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
         a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
         if ($urandom % 4 != 0) a = a & ~32'(sz - 1);
         if ($urandom % 8 == 0) begin
            r = $urandom % 4;
            a = r == 0 ? BASE - 4 : r == 1 ? BASE + 32'(4 * DEPTH) : r == 2 ? BASE - 1 : 32'hFFFF_FFFC;
         end
         req(rd, wr, a, $urandom, f3, 1'b0);
      end
      repeat (5) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef RISCV_DMEM_STATS_EN
      check("rd_count", rd_count, 32'(n_rd));
      check("wr_count", wr_count, 32'(n_wr));
      check("err_count", 32'(err_count), 32'(n_err));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
